// File: rtl/fb_wr_sched.sv
// Frame-buffer write scheduler: turns 8x8-block-ordered pixels into raster-addressed writes.
// The optional full-frame clear engine is built only when FB_SCHED_CLEAR_EN is defined.
module fb_wr_sched #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [23:0]           pix_data,
   input  logic                  clear_req,
   input  logic [23:0]           clear_color,
   output logic                  clear_busy,
   output logic                  fb_wr_en,
   output logic [ADDR_WIDTH-1:0] fb_wr_addr,
   output logic [23:0]           fb_wr_data,
   output logic                  frame_done
);
   localparam int BXW = (WIDTH / 8 > 1) ? $clog2(WIDTH / 8) : 1;
   localparam logic [BXW-1:0]        BX_LAST   = BXW'(WIDTH / 8 - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BLK_STEP  = ADDR_WIDTH'(8 * WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_BLK  = ADDR_WIDTH'((HEIGHT - 8) * WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
`ifdef FB_SCHED_CLEAR_EN
      S_CLEAR  = 2'd2,
`endif
      S_ACTIVE = 2'd1
   } state_t;

   state_t                state_q;
   logic [2:0]            px_q;
   logic [2:0]            py_q;
   logic [BXW-1:0]        bx_q;
   logic [ADDR_WIDTH-1:0] blk_base_q;
   logic [ADDR_WIDTH-1:0] row_off_q;
   logic                  pix_ready_q;
   logic                  clear_busy_q;
   logic                  fb_wr_en_q;
   logic [ADDR_WIDTH-1:0] fb_wr_addr_q;
   logic [23:0]           fb_wr_data_q;
   logic                  frame_done_q;
   logic                  accept_s;
   logic                  last_pix_s;
   logic                  frame_go_s;
   logic [ADDR_WIDTH-1:0] pix_addr_s;

`ifdef FB_SCHED_CLEAR_EN
   logic                  clear_pend_q;
   logic                  frame_pend_q;
   logic [23:0]           clr_color_q;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   assign frame_go_s = frame_start | frame_pend_q;
`else
   logic unused_clear_s;
   assign unused_clear_s = ^{clear_req, clear_color};
   assign frame_go_s     = frame_start;
`endif

   // Raster address = block-row base + row-within-block offset + column {bx,px}.
   assign pix_addr_s = blk_base_q + row_off_q + ADDR_WIDTH'({bx_q, px_q});
   assign accept_s   = pix_valid & pix_ready_q;
   assign last_pix_s = (px_q == 3'd7) && (py_q == 3'd7) && (bx_q == BX_LAST) && (blk_base_q == LAST_BLK);

   assign pix_ready  = pix_ready_q;
   assign clear_busy = clear_busy_q;
   assign fb_wr_en   = fb_wr_en_q;
   assign fb_wr_addr = fb_wr_addr_q;
   assign fb_wr_data = fb_wr_data_q;
   assign frame_done = frame_done_q;

   // Scheduler FSM with address counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         px_q         <= 3'd0;
         py_q         <= 3'd0;
         bx_q         <= {BXW{1'b0}};
         blk_base_q   <= ZERO_ADDR;
         row_off_q    <= ZERO_ADDR;
         pix_ready_q  <= 1'b0;
         clear_busy_q <= 1'b0;
         fb_wr_en_q   <= 1'b0;
         fb_wr_addr_q <= ZERO_ADDR;
         fb_wr_data_q <= 24'h000000;
         frame_done_q <= 1'b0;
`ifdef FB_SCHED_CLEAR_EN
         clear_pend_q <= 1'b0;
         frame_pend_q <= 1'b0;
         clr_color_q  <= 24'h000000;
         clr_addr_q   <= ZERO_ADDR;
`endif
      end else begin
         fb_wr_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
`ifdef FB_SCHED_CLEAR_EN
               if (clear_req || clear_pend_q) begin
                  state_q      <= S_CLEAR;
                  clear_busy_q <= 1'b1;
                  clear_pend_q <= 1'b0;
                  clr_addr_q   <= ZERO_ADDR;
                  if (clear_req) clr_color_q <= clear_color;
                  if (frame_start) frame_pend_q <= 1'b1;
               end else
`endif
               if (frame_go_s) begin
                  state_q     <= S_ACTIVE;
                  pix_ready_q <= 1'b1;
                  px_q        <= 3'd0;
                  py_q        <= 3'd0;
                  bx_q        <= {BXW{1'b0}};
                  blk_base_q  <= ZERO_ADDR;
                  row_off_q   <= ZERO_ADDR;
`ifdef FB_SCHED_CLEAR_EN
                  frame_pend_q <= 1'b0;
`endif
               end
            end
            S_ACTIVE: begin
`ifdef FB_SCHED_CLEAR_EN
               if (clear_req) begin
                  clear_pend_q <= 1'b1;
                  clr_color_q  <= clear_color;
               end
`endif
               // A restart wins over a pixel offered in the same cycle.
               if (frame_start) begin
                  px_q       <= 3'd0;
                  py_q       <= 3'd0;
                  bx_q       <= {BXW{1'b0}};
                  blk_base_q <= ZERO_ADDR;
                  row_off_q  <= ZERO_ADDR;
               end else if (accept_s) begin
                  fb_wr_en_q   <= 1'b1;
                  fb_wr_addr_q <= pix_addr_s;
                  fb_wr_data_q <= pix_data;
                  px_q         <= px_q + 3'd1;
                  if (px_q == 3'd7) begin
                     py_q <= py_q + 3'd1;
                     if (py_q == 3'd7) begin
                        row_off_q <= ZERO_ADDR;
                        if (bx_q == BX_LAST) begin
                           bx_q       <= {BXW{1'b0}};
                           blk_base_q <= last_pix_s ? ZERO_ADDR : blk_base_q + BLK_STEP;
                        end else begin
                           bx_q <= bx_q + BXW'(1);
                        end
                     end else begin
                        row_off_q <= row_off_q + ROW_STEP;
                     end
                  end
                  if (last_pix_s) begin
                     frame_done_q <= 1'b1;
                     state_q      <= S_IDLE;
                     pix_ready_q  <= 1'b0;
                  end
               end
            end
`ifdef FB_SCHED_CLEAR_EN
            S_CLEAR: begin
               fb_wr_en_q   <= 1'b1;
               fb_wr_addr_q <= clr_addr_q;
               fb_wr_data_q <= clr_color_q;
               if (frame_start) frame_pend_q <= 1'b1;
               if (clr_addr_q == LAST_ADDR) begin
                  clr_addr_q   <= ZERO_ADDR;
                  frame_done_q <= 1'b1;
                  clear_busy_q <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  clr_addr_q <= clr_addr_q + ZERO_ADDR + ADDR_WIDTH'(1);
               end
            end
`endif
            default: begin
               state_q      <= S_IDLE;
               pix_ready_q  <= 1'b0;
               clear_busy_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/fb_wr_sched.md
FB_WR_SCHED -- requirements
Module: fb_wr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 640: frame width in pixels, a multiple of 8.
REQ-002 SHALL have parameter HEIGHT, default 480: frame height in pixels, a multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19: frame-buffer address width, at least ceil(log2(WIDTH*HEIGHT)).
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start, input, 1: one-cycle request to begin accepting a frame.
REQ-007 SHALL have port pix_valid, input, 1: decoder pixel valid.
REQ-008 SHALL have port pix_ready, output, 1: block accepts a pixel this cycle.
REQ-009 SHALL have port pix_data, input, 24: {R,G,B} 8 bits each, in 8x8 block order.
REQ-010 SHALL have port clear_req, input, 1: one-cycle request to fill the frame with clear_color.
REQ-011 SHALL have port clear_color, input, 24: fill colour, sampled on clear_req acceptance.
REQ-012 SHALL have port clear_busy, output, 1: clear sweep in progress.
REQ-013 SHALL have port fb_wr_en, output, 1: frame-buffer write strobe.
REQ-014 SHALL have port fb_wr_addr, output, ADDR_WIDTH: raster write address.
REQ-015 SHALL have port fb_wr_data, output, 24: write data.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse on the last write of a frame or clear.

Function
REQ-017 SHALL implement states IDLE, ACTIVE and CLEAR.
REQ-018 SHALL assert pix_ready only in ACTIVE; a pixel is accepted when pix_valid and pix_ready are both high.
REQ-019 SHALL map the accepted pixel index to raster address (by*8+py)*WIDTH + bx*8+px.
- Input order: px fastest (0..7), then py (0..7), then bx (0..WIDTH/8-1), then by.
- Address generation: counters and a running row base only, no multiplier.
REQ-020 SHALL drive fb_wr_en/addr/data from registers, one cycle after acceptance; fb_wr_en is low on cycles with no acceptance.
REQ-021 SHALL go IDLE->ACTIVE on frame_start, with counters zeroed.
REQ-022 SHALL go ACTIVE->IDLE on acceptance of pixel WIDTH*HEIGHT-1; frame_done SHALL pulse with that write.
REQ-023 SHALL, on frame_start while in ACTIVE, zero the counters (abort and restart); a pixel accepted in the same cycle is dropped.
REQ-024 SHALL go IDLE->CLEAR on clear_req, latching clear_color, and write addresses 0..WIDTH*HEIGHT-1 one per cycle, with clear_busy high.
REQ-025 SHALL go CLEAR->IDLE after the final clear write, which SHALL coincide with a frame_done pulse.
REQ-026 SHALL latch a clear_req arriving in ACTIVE as pending and enter CLEAR in the cycle after the frame completes.
REQ-027 SHALL latch a frame_start arriving in CLEAR as pending and enter ACTIVE in the cycle after the clear completes.
REQ-028 SHALL, when frame_start and clear_req coincide in IDLE, give CLEAR priority and hold frame_start pending.
REQ-029 SHALL wrap the address counters to 0 after the final write; no address SHALL exceed WIDTH*HEIGHT-1.

Reset
REQ-030 SHALL, on rst_n low, immediately force the state to IDLE, zero all counters and pending flags, and drive pix_ready, clear_busy, fb_wr_en and frame_done to 0 and fb_wr_addr and fb_wr_data to 0.
REQ-031 SHALL, on reset mid-frame or mid-clear, discard the operation; after release it SHALL wait in IDLE for a new request.

Configuration
REQ-032 SHALL compile the clear engine only when macro FB_SCHED_CLEAR_EN is defined; with FB_SCHED_CLEAR_EN defined, REQ-024..028 apply.
REQ-033 SHALL, without FB_SCHED_CLEAR_EN, omit the CLEAR state, ignore clear_req and clear_color, and tie clear_busy to 0.

Verification (WIDTH=16, HEIGHT=16, ADDR_WIDTH=8)
REQ-034 Frame order: frame_start then 256 back-to-back pixels -> pixel 8 writes addr 16, pixel 64 writes addr 8, pixel 128 writes addr 128, pixel 255 writes addr 255 with frame_done, then IDLE.
REQ-035 Backpressure: pix_valid toggled every other cycle -> writes only on accepted cycles, addresses contiguous in the mapping, write latency 1.
REQ-036 Clear: clear_req with clear_color=24'h102030 -> 256 consecutive writes, addr 0..255, data 102030, clear_busy high for 256 cycles, frame_done on addr 255.
REQ-037 Collisions: clear_req at pixel 100 of a frame -> frame finishes unchanged, then clear starts the next cycle; frame_start and clear_req together in IDLE -> clear first, then ACTIVE.
REQ-038 Reset: rst_n low at pixel 40 -> all outputs 0 asynchronously; after release and frame_start, the first write is at addr 0.
REQ-039 Restart: frame_start at pixel 70 -> the next accepted pixel writes addr 0.
